mc_signal_generator: RTL and testbench

//  Transmit end of the motor-controller (MC) link. Takes the 5-bit MC packet MCP
//  {power[4:2], dir[1:0]} from acceleration modulation and emits the periodic

---
 rtl/mc_signal_generator_if.sv | 20 ++
 rtl/mc_signal_generator.sv | 147 ++++++++++++++
 tb/tb_mc_signal_generator.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mc_signal_generator_if.sv
// Motor-controller link bus: requested packet in, pulse and status out.
interface mc_signal_generator_if;
    logic [4:0] mcp;
    logic       mcp_update;
    logic       mc_pwm;
    logic [4:0] current_mc;
    logic       frame_start;
    logic       code_err;
    logic       failsafe;

    modport master (
        output mcp, mcp_update,
        input  mc_pwm, current_mc, frame_start, code_err, failsafe
    );

    modport slave (
        input  mcp, mcp_update,
        output mc_pwm, current_mc, frame_start, code_err, failsafe
    );
endinterface

// File: rtl/mc_signal_generator.sv
// Servo-style pulse generator for the motor-controller link: one pulse per frame.
// Optional MCP_UPDATE watchdog forcing neutral is enabled by defining MC_FAILSAFE_EN.
module mc_signal_generator #(
    parameter int unsigned CNT_W          = 20,
    parameter int unsigned FRAME_CYCLES   = 550000,
    parameter int unsigned PULSE_NEUTRAL  = 75000,
    parameter int unsigned PULSE_STEP     = 6250,
    parameter int unsigned TIMEOUT_FRAMES = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    mc_signal_generator_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] NEUTRAL_W  = CNT_W'(PULSE_NEUTRAL);
    localparam logic [CNT_W-1:0] STEP_W     = CNT_W'(PULSE_STEP);
    localparam logic [4:0]       CODE_NEUT  = 5'b00001;

    state_e           state_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] width_q;
    logic             pwm_q;
    logic [4:0]       current_mc_q;
    logic             frame_start_q;
    logic             code_err_q;

    logic             boundary_c;
    logic             force_c;
    logic [3:0]       level_c;
    logic [CNT_W-1:0] delta_c;
    logic [4:0]       code_c;
    logic [CNT_W-1:0] width_c;
    logic             code_err_c;

    assign boundary_c = (frame_cnt_q == '0);
    assign level_c    = {1'b0, bus.mcp[4:2]} + 4'd1;
    assign delta_c    = CNT_W'(level_c) * STEP_W;

`ifdef MC_FAILSAFE_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_FRAMES + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            failsafe_q;

    // A boundary that brings the count to the timeout forces neutral; an update on it wins.
    assign force_c = boundary_c && !bus.mcp_update
                     && (wd_cnt_q >= WD_W'(TIMEOUT_FRAMES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q   <= '0;
            failsafe_q <= 1'b0;
        end else if (bus.mcp_update) begin
            wd_cnt_q   <= '0;
            failsafe_q <= 1'b0;
        end else if (boundary_c) begin
            if (wd_cnt_q != WD_W'(TIMEOUT_FRAMES)) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (force_c) begin
                failsafe_q <= 1'b1;
            end
        end
    end

    assign bus.failsafe = failsafe_q;
`else
    logic unused_mcp_update;

    assign unused_mcp_update = bus.mcp_update;
    assign force_c           = 1'b0;
    assign bus.failsafe      = 1'b0;
`endif

    // Resolve the requested packet into the transmitted code and pulse width.
    always_comb begin
        code_c     = bus.mcp;
        width_c    = NEUTRAL_W;
        code_err_c = 1'b0;
        if (force_c) begin
            code_c = CODE_NEUT;
        end else begin
            case (bus.mcp[1:0])
                2'b10:   width_c = NEUTRAL_W + delta_c;
                2'b00:   width_c = NEUTRAL_W - delta_c;
                2'b11: begin
                    code_c     = CODE_NEUT;
                    code_err_c = 1'b1;
                end
                default: width_c = NEUTRAL_W;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || (frame_cnt_q == FRAME_LAST)) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            width_q       <= NEUTRAL_W;
            pwm_q         <= 1'b0;
            current_mc_q  <= CODE_NEUT;
            frame_start_q <= 1'b0;
            code_err_q    <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (boundary_c) begin
                state_q       <= HIGH;
                width_q       <= width_c;
                pwm_q         <= 1'b1;
                current_mc_q  <= code_c;
                frame_start_q <= 1'b1;
                code_err_q    <= code_err_c;
            end else begin
                case (state_q)
                    HIGH: begin
                        if (frame_cnt_q == width_q) begin
                            state_q <= LOW;
                            pwm_q   <= 1'b0;
                        end
                    end
                    LOW:     state_q <= LOW;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.mc_pwm      = pwm_q;
    assign bus.current_mc  = current_mc_q;
    assign bus.frame_start = frame_start_q;
    assign bus.code_err    = code_err_q;

endmodule

// File: tb/tb_mc_signal_generator.sv
// Frame-level bench for mc_signal_generator with scaled-down timing parameters.
module tb_mc_signal_generator;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned FRAME = 200;
    localparam int unsigned NEUT  = 80;
    localparam int unsigned STEP  = 8;
    localparam int unsigned TMO   = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mc_signal_generator_if bus_if();

    mc_signal_generator #(
        .CNT_W          (CNT_W),
        .FRAME_CYCLES   (FRAME),
        .PULSE_NEUTRAL  (NEUT),
        .PULSE_STEP     (STEP),
        .TIMEOUT_FRAMES (TMO)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus_if.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int wd_frames   = 0;
    bit fs_model    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_width(input logic [4:0] m);
        int lvl;
        lvl = int'(m[4:2]) + 1;
        case (m[1:0])
            2'b10:   return int'(NEUT) + lvl * int'(STEP);
            2'b00:   return int'(NEUT) - lvl * int'(STEP);
            default: return int'(NEUT);
        endcase
    endfunction

    // Called at the negedge just before a boundary; leaves off at the negedge before the next one.
    task automatic run_frame(input logic [4:0] m, input bit upd_bnd, input int upd_at,
                             input int chg_at, input logic [4:0] chg_val);
        int         highs;
        int         starts;
        bit         forced;
        logic [4:0] e_code;
        int         e_w;
        bit         e_err;
        highs  = 0;
        starts = 0;
        forced = 1'b0;
        bus_if.mcp        = m;
        bus_if.mcp_update = upd_bnd;
`ifdef MC_FAILSAFE_EN
        if (upd_bnd) begin
            wd_frames = 0;
            fs_model  = 1'b0;
        end else begin
            if (wd_frames < int'(TMO)) wd_frames++;
            if (wd_frames >= int'(TMO)) begin
                forced   = 1'b1;
                fs_model = 1'b1;
            end
        end
`endif
        if (forced) begin
            e_code = 5'b00001; e_w = int'(NEUT); e_err = 1'b0;
        end else if (m[1:0] == 2'b11) begin
            e_code = 5'b00001; e_w = int'(NEUT); e_err = 1'b1;
        end else begin
            e_code = m; e_w = exp_width(m); e_err = 1'b0;
        end
        for (int i = 0; i < int'(FRAME); i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus_if.mcp_update = 1'b0;
                check_eq("frame_start", 32'(bus_if.frame_start), 32'd1);
                check_eq("current_mc", 32'(bus_if.current_mc), 32'(e_code));
                check_eq("code_err", 32'(bus_if.code_err), 32'(e_err));
                check_eq("failsafe", 32'(bus_if.failsafe), 32'(fs_model));
            end
            if (bus_if.mc_pwm) highs++;
            if (bus_if.frame_start) starts++;
            if (i == e_w - 1) check_eq("pwm_last_high", 32'(bus_if.mc_pwm), 32'd1);
            if (i == e_w) check_eq("pwm_first_low", 32'(bus_if.mc_pwm), 32'd0);
            if (i == upd_at) bus_if.mcp_update = 1'b1;
            else if (i == upd_at + 1) bus_if.mcp_update = 1'b0;
            if (i == chg_at) bus_if.mcp = chg_val;
        end
`ifdef MC_FAILSAFE_EN
        if (upd_at > 0) begin
            wd_frames = 0;
            fs_model  = 1'b0;
        end
`endif
        check_eq("pulse_width", 32'(highs), 32'(e_w));
        check_eq("starts_per_frame", 32'(starts), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pwm"}, 32'(bus_if.mc_pwm), 32'd0);
        check_eq({tag, "_current_mc"}, 32'(bus_if.current_mc), 32'd1);
        check_eq({tag, "_frame_start"}, 32'(bus_if.frame_start), 32'd0);
        check_eq({tag, "_code_err"}, 32'(bus_if.code_err), 32'd0);
        check_eq({tag, "_failsafe"}, 32'(bus_if.failsafe), 32'd0);
    endtask

    initial begin
        #(10 * 100000);
        $display("FAIL sim_timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] m;
        logic [4:0] cv;
        bit         ub;
        int         ua;
        int         ca;

        rst               = 1'b1;
        bus_if.mcp        = 5'b00001;
        bus_if.mcp_update = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed frames: neutral, full forward, minimum reverse, invalid, recovery.
        run_frame(5'b00001, 1'b1, -1, -1, 5'b00000);
        run_frame(5'b00001, 1'b1, -1, -1, 5'b00000);
        run_frame(5'b11110, 1'b1, -1, -1, 5'b00000);
        run_frame(5'b00000, 1'b1, -1, -1, 5'b00000);
        run_frame(5'b01011, 1'b1, -1, -1, 5'b00000);
        run_frame(5'b00110, 1'b1, -1, -1, 5'b00000);
        run_frame(5'b10101, 1'b1, -1, -1, 5'b00000);
        // Mid-frame change must not disturb the pulse in flight.
        run_frame(5'b00001, 1'b1, -1, 5, 5'b11110);
        run_frame(5'b11110, 1'b1, -1, -1, 5'b00000);

        // Reset while the pulse is high.
        bus_if.mcp        = 5'b11110;
        bus_if.mcp_update = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus_if.mcp_update = 1'b0;
        end
        check_eq("pre_reset_pwm", 32'(bus_if.mc_pwm), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        wd_frames = 0;
        fs_model  = 1'b0;
        run_frame(5'b10010, 1'b0, -1, -1, 5'b00000);

        // Randomized frames with random updates and mid-frame packet changes.
        for (int f = 0; f < 30; f++) begin
            m  = 5'($urandom);
            cv = 5'($urandom);
            ub = ($urandom_range(0, 3) == 0);
            ua = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, FRAME - 3)) : -1;
            ca = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, FRAME - 2)) : -1;
            run_frame(m, ub, ua, ca, cv);
        end

        // Watchdog: starve MCP_UPDATE, then recover with one mid-frame update.
        run_frame(5'b11110, 1'b1, -1, -1, 5'b00000);
        for (int f = 0; f < 5; f++) begin
            run_frame(5'b11110, 1'b0, -1, -1, 5'b00000);
        end
        run_frame(5'b11110, 1'b0, 50, -1, 5'b00000);
        run_frame(5'b11110, 1'b0, -1, -1, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
